// File: rtl/cr_im_producer_pkg.sv
// rtl/cr_im_producer_pkg.sv - bank states, bank indices and stat helpers for cr_im_producer
package cr_im_producer_pkg;

  typedef enum logic [1:0] {
    IM_FREE    = 2'd0,
    IM_FILLING = 2'd1,
    IM_AVAIL   = 2'd2
  } im_bank_state_e;

  localparam logic IM_BANK_LO = 1'b0;
  localparam logic IM_BANK_HI = 1'b1;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  // Saturating increment: sticks at STAT_MAX instead of wrapping.
  function automatic logic [31:0] stat_sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != STAT_MAX)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/cr_structs.sv
// rtl/cr_structs.sv - shared packed structs for the interface-memory handshake
package cr_structs;

  typedef struct packed {
    logic bank_hi;
    logic bank_lo;
  } im_available_t;

  typedef struct packed {
    logic bank_hi;
    logic bank_lo;
  } im_consumed_t;

endpackage

// File: rtl/cr_im_bank_fsm.sv
// rtl/cr_im_bank_fsm.sv - lifecycle of one IM bank: FREE -> FILLING -> AVAIL -> FREE
module cr_im_bank_fsm
  import cr_im_producer_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sel,
  input  logic           accept,
  input  logic           close,
  input  logic           consumed,
  output im_bank_state_e state,
  output logic           avail,
  output logic           err
);

  // State plus registered flags; avail trails the AVAIL state by one cycle so it
  // rises after the closing entry's write strobe, and a release clears it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IM_FREE;
      avail <= 1'b0;
      err   <= 1'b0;
    end else begin
      avail <= (state == IM_AVAIL) && !consumed;
      err   <= consumed && (state != IM_AVAIL);
      case (state)
        IM_FREE: begin
          if (sel && accept) begin
            state <= close ? IM_AVAIL : IM_FILLING;
          end
        end
        IM_FILLING: begin
          if (sel && accept && close) begin
            state <= IM_AVAIL;
          end
        end
        IM_AVAIL: begin
          if (consumed) begin
            state <= IM_FREE;
          end
        end
        default: state <= IM_FREE;
      endcase
    end
  end

endmodule

// File: rtl/cr_im_producer.sv
// rtl/cr_im_producer.sv - ping-pong IM writer with per-bank availability; stats under CR_IM_PRODUCER_STATS_EN
module cr_im_producer
  import cr_im_producer_pkg::*;
  import cr_structs::*;
#(
  parameter int IM_DEPTH = 1024,
  parameter int DATA_W   = 64,
  parameter int AW       = $clog2(IM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_vld,
  output logic              wr_rdy,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              im_wr_en,
  output logic [AW-1:0]     im_wr_addr,
  output logic [DATA_W-1:0] im_wr_data,
  output im_available_t     im_available,
  input  im_consumed_t      im_consumed,
  output logic [AW-1:0]     im_lo_cnt,
  output logic [AW-1:0]     im_hi_cnt,
  output logic              im_err,
  output logic [31:0]       stat_frames,
  output logic [31:0]       stat_stall
);

  logic           ptr;
  logic [AW-1:0]  fill_cnt;
  logic [AW-1:0]  cnt_nxt;
  logic           rdy_en;
  logic           accept;
  logic           full;
  logic           close;
  logic [AW-1:0]  lo_cnt_q;
  logic [AW-1:0]  hi_cnt_q;

  im_bank_state_e lo_state;
  im_bank_state_e hi_state;
  logic           lo_avail;
  logic           hi_avail;
  logic           lo_err;
  logic           hi_err;

  // rdy_en keeps wr_rdy low while in reset; otherwise ready follows the selected bank only.
  assign wr_rdy  = rdy_en && ((ptr == IM_BANK_HI) ? (hi_state != IM_AVAIL)
                                                  : (lo_state != IM_AVAIL));
  assign accept  = wr_vld && wr_rdy;
  assign cnt_nxt = fill_cnt + AW'(1);
  // Fill count never exceeds BANK, so reaching BANK is the carry into the top bit.
  assign full    = cnt_nxt[AW-1];
  // A full bank that also carries wr_last is still a single close.
  assign close   = accept && (wr_last || full);

  cr_im_bank_fsm u_bank_lo (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (ptr == IM_BANK_LO),
    .accept   (accept),
    .close    (close),
    .consumed (im_consumed.bank_lo),
    .state    (lo_state),
    .avail    (lo_avail),
    .err      (lo_err)
  );

  cr_im_bank_fsm u_bank_hi (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (ptr == IM_BANK_HI),
    .accept   (accept),
    .close    (close),
    .consumed (im_consumed.bank_hi),
    .state    (hi_state),
    .avail    (hi_avail),
    .err      (hi_err)
  );

  // Bank pointer, fill count and the entry count captured when a bank closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= IM_BANK_LO;
      fill_cnt <= '0;
      rdy_en   <= 1'b0;
      lo_cnt_q <= '0;
      hi_cnt_q <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        if (close) begin
          fill_cnt <= '0;
          ptr      <= ~ptr;
          if (ptr == IM_BANK_HI) begin
            hi_cnt_q <= cnt_nxt;
          end else begin
            lo_cnt_q <= cnt_nxt;
          end
        end else begin
          fill_cnt <= cnt_nxt;
        end
      end
    end
  end

  // IM write port: one cycle behind the handshake, address = bank base + fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
    end else begin
      im_wr_en <= accept;
      if (accept) begin
        im_wr_addr <= {ptr, fill_cnt[AW-2:0]};
        im_wr_data <= wr_data;
      end
    end
  end

  // Published counts move in the same cycle as the matching available bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_lo_cnt <= '0;
      im_hi_cnt <= '0;
    end else begin
      im_lo_cnt <= lo_cnt_q;
      im_hi_cnt <= hi_cnt_q;
    end
  end

  assign im_available.bank_lo = lo_avail;
  assign im_available.bank_hi = hi_avail;
  assign im_err               = lo_err | hi_err;

`ifdef CR_IM_PRODUCER_STATS_EN
  logic [31:0] frames_q;
  logic [31:0] stall_q;

  // Saturating counts of closed banks and of cycles the source was held off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
      stall_q  <= '0;
    end else begin
      frames_q <= stat_sat_inc(frames_q, close);
      stall_q  <= stat_sat_inc(stall_q, wr_vld && !wr_rdy);
    end
  end

  assign stat_frames = frames_q;
  assign stat_stall  = stall_q;
`else
  assign stat_frames = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_cr_im_producer.sv
// tb/tb_cr_im_producer.sv - directed bench with a behavioural ping-pong model for cr_im_producer
module tb_cr_im_producer;
  import cr_structs::*;

  localparam int IM_DEPTH = 8;
  localparam int DATA_W   = 16;
  localparam int AW       = 3;
  localparam int BANK     = IM_DEPTH / 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_vld = 1'b0;
  logic              wr_last = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_rdy;
  logic              im_wr_en;
  logic [AW-1:0]     im_wr_addr;
  logic [DATA_W-1:0] im_wr_data;
  im_available_t     im_available;
  im_consumed_t      im_consumed = '0;
  logic [AW-1:0]     im_lo_cnt;
  logic [AW-1:0]     im_hi_cnt;
  logic              im_err;
  logic [31:0]       stat_frames;
  logic [31:0]       stat_stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cr_im_producer #(.IM_DEPTH(IM_DEPTH), .DATA_W(DATA_W), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_vld       (wr_vld),
    .wr_rdy       (wr_rdy),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .im_wr_en     (im_wr_en),
    .im_wr_addr   (im_wr_addr),
    .im_wr_data   (im_wr_data),
    .im_available (im_available),
    .im_consumed  (im_consumed),
    .im_lo_cnt    (im_lo_cnt),
    .im_hi_cnt    (im_hi_cnt),
    .im_err       (im_err),
    .stat_frames  (stat_frames),
    .stat_stall   (stat_stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a bank is "held" from its closing handshake until released; the
  // consumer-visible flag and count appear one cycle after the hold begins.
  bit                m_held [2];
  bit                m_avail[2];
  bit                m_pend [2];
  int                m_pend_cnt[2];
  int                m_cnt  [2];
  bit                m_ptr;
  int                m_fill;
  bit                m_gate;
  bit                e_en;
  bit                e_err;
  int                e_addr;
  logic [DATA_W-1:0] e_data;
  longint            m_frames;
  longint            m_stall;

  function automatic bit m_rdy();
    return m_gate && !m_held[m_ptr];
  endfunction

  task automatic model_step();
    bit acc;
    bit cons[2];
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        m_held[b] = 0; m_avail[b] = 0; m_pend[b] = 0; m_pend_cnt[b] = 0; m_cnt[b] = 0;
      end
      m_ptr = 0; m_fill = 0; m_gate = 0; e_en = 0; e_err = 0; e_addr = 0; e_data = '0;
      m_frames = 0; m_stall = 0;
    end else begin
      cons[0] = im_consumed.bank_lo;
      cons[1] = im_consumed.bank_hi;
      acc = wr_vld && m_rdy();
      if (wr_vld && !m_rdy()) m_stall++;
      e_err = 0;
      for (int b = 0; b < 2; b++) begin
        if (cons[b]) begin
          if (m_held[b]) begin
            m_held[b] = 0; m_avail[b] = 0; m_pend[b] = 0;
          end else begin
            e_err = 1;
          end
        end
      end
      for (int b = 0; b < 2; b++) begin
        if (m_pend[b]) begin
          m_avail[b] = 1; m_cnt[b] = m_pend_cnt[b]; m_pend[b] = 0;
        end
      end
      e_en = acc;
      if (acc) begin
        e_addr = m_ptr * BANK + m_fill;
        e_data = wr_data;
        m_fill++;
        if (wr_last || m_fill == BANK) begin
          m_held[m_ptr] = 1;
          m_pend[m_ptr] = 1;
          m_pend_cnt[m_ptr] = m_fill;
          m_fill = 0;
          m_ptr = !m_ptr;
          m_frames++;
        end
      end
      m_gate = 1;
    end
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  always begin
    @(negedge clk);
    check("wr_rdy", wr_rdy, m_rdy());
    check("im_wr_en", im_wr_en, e_en);
    if (e_en) begin
      check("im_wr_addr", im_wr_addr, e_addr);
      check("im_wr_data", im_wr_data, e_data);
    end
    check("avail_lo", im_available.bank_lo, m_avail[0]);
    check("avail_hi", im_available.bank_hi, m_avail[1]);
    if (m_avail[0]) check("im_lo_cnt", im_lo_cnt, m_cnt[0]);
    if (m_avail[1]) check("im_hi_cnt", im_hi_cnt, m_cnt[1]);
    check("im_err", im_err, e_err);
`ifdef CR_IM_PRODUCER_STATS_EN
    check("stat_frames", stat_frames, m_frames);
    check("stat_stall", stat_stall, m_stall);
`else
    check("stat_frames_off", stat_frames, 0);
    check("stat_stall_off", stat_stall, 0);
`endif
  end

  // Called at a negedge; returns at the negedge following the handshake.
  task automatic push(input logic [DATA_W-1:0] d, input logic l);
    int n;
    n = 0;
    wr_vld = 1'b1; wr_data = d; wr_last = l;
    while (wr_rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL push_timeout: got no wr_rdy within %0d cycles expected handshake", n);
    end
    @(negedge clk);
    wr_vld = 1'b0; wr_last = 1'b0;
  endtask

  task automatic consume(input logic lo, input logic hi);
    im_consumed.bank_lo = lo;
    im_consumed.bank_hi = hi;
    @(negedge clk);
    im_consumed = '0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_wr_rdy", wr_rdy, 0);
    check("rst_avail", im_available, 0);
    check("rst_wr_en", im_wr_en, 0);
    check("rst_addr", im_wr_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Short frame in lo
    push(16'h0a00, 1'b0); check("t1_addr0", im_wr_addr, 0);
    push(16'h0a01, 1'b0); check("t1_addr1", im_wr_addr, 1);
    push(16'h0a02, 1'b1); check("t1_addr2", im_wr_addr, 2); check("t1_en", im_wr_en, 1);
    check("t1_lo_not_yet", im_available.bank_lo, 0);
    @(negedge clk);
    check("t1_lo_avail", im_available.bank_lo, 1);
    check("t1_lo_cnt", im_lo_cnt, 3);

    // Next entry lands in hi
    push(16'h0b00, 1'b0); check("t1_next_addr", im_wr_addr, 4);

    // Illegal release of a filling bank
    consume(1'b0, 1'b1);
    check("t4_err", im_err, 1);
    check("t4_hi_unchanged", im_available.bank_hi, 0);
    check("t4_lo_unchanged", im_available.bank_lo, 1);
    @(negedge clk);
    check("t4_err_pulse", im_err, 0);

    // Fill hi to BANK without wr_last
    push(16'h0b01, 1'b0); check("t2_addr5", im_wr_addr, 5);
    push(16'h0b02, 1'b0); check("t2_addr6", im_wr_addr, 6);
    push(16'h0b03, 1'b0); check("t2_addr7", im_wr_addr, 7);
    check("t2_rdy_low", wr_rdy, 0);
    @(negedge clk);
    check("t2_hi_avail", im_available.bank_hi, 1);
    check("t2_hi_cnt", im_hi_cnt, 4);

    // Both banks held: source stalls until lo is released
    wr_vld = 1'b1; wr_data = 16'h0c00; wr_last = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_rdy_low", wr_rdy, 0);
`ifdef CR_IM_PRODUCER_STATS_EN
    check("t3_stall4", stat_stall, 4);
    check("t3_frames2", stat_frames, 2);
`endif
    consume(1'b1, 1'b0);
    check("t3_lo_cleared", im_available.bank_lo, 0);
    check("t3_rdy_back", wr_rdy, 1);
    @(negedge clk);
    wr_vld = 1'b0;
    check("t3_addr0", im_wr_addr, 0);
    check("t3_data", im_wr_data, 16'h0c00);

    // Release hi, then fill lo to BANK with wr_last on the final entry
    consume(1'b0, 1'b1);
    push(16'h0d01, 1'b0); check("t5_addr1", im_wr_addr, 1);
    push(16'h0d02, 1'b0); check("t5_addr2", im_wr_addr, 2);
    push(16'h0d03, 1'b1); check("t5_addr3", im_wr_addr, 3);
    @(negedge clk);
    check("t5_lo_avail", im_available.bank_lo, 1);
    check("t5_lo_cnt", im_lo_cnt, 4);
    push(16'h0e00, 1'b0); check("t5_single_close", im_wr_addr, 4);

    // Release lo in the same cycle as hi's closing handshake
    check("t5_rdy_pre", wr_rdy, 1);
    wr_vld = 1'b1; wr_data = 16'h0e01; wr_last = 1'b1;
    im_consumed.bank_lo = 1'b1;
    @(negedge clk);
    wr_vld = 1'b0; wr_last = 1'b0; im_consumed = '0;
    check("t5_same_addr", im_wr_addr, 5);
    check("t5_same_lo_free", im_available.bank_lo, 0);
    @(negedge clk);
    check("t5_same_hi_avail", im_available.bank_hi, 1);
    check("t5_same_hi_cnt", im_hi_cnt, 2);
`ifdef CR_IM_PRODUCER_STATS_EN
    check("t5_frames4", stat_frames, 4);
`endif

    // Both release bits together: lo is FREE (error), hi is AVAIL (released)
    consume(1'b1, 1'b1);
    check("t5_both_err", im_err, 1);
    check("t5_both_hi_free", im_available.bank_hi, 0);

    // Asynchronous reset mid-frame
    push(16'h0f00, 1'b0); check("t6_addr0", im_wr_addr, 0);
    push(16'h0f01, 1'b0); check("t6_addr1", im_wr_addr, 1);
    wr_vld = 1'b1; wr_data = 16'h0f02;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_rdy", wr_rdy, 0);
    check("t6_rst_en", im_wr_en, 0);
    check("t6_rst_addr", im_wr_addr, 0);
    check("t6_rst_data", im_wr_data, 0);
    check("t6_rst_avail", im_available, 0);
    check("t6_rst_err", im_err, 0);
    check("t6_rst_frames", stat_frames, 0);
    wr_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(16'h1000, 1'b0);
    check("t6_post_addr", im_wr_addr, 0);
    check("t6_post_data", im_wr_data, 16'h1000);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    checks++; errors++;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cr_im_producer.md
Name: cr_im_producer

Overview:
- Write-side end of the interface-memory (IM) handshake: fills a two-bank ping-pong IM, raises im_available per bank, frees banks on im_consumed pulses from the consuming support/regfile logic.
- Sits between an engine's output stream (e.g. lz77c, xpd, he_sh) and its IM instance.
- One instance per IM.

Parameters:
- IM_DEPTH, 1024, total IM entries; bank size BANK = IM_DEPTH/2; must be a power of 2, minimum 4.
- DATA_W, 64, IM entry width.
- AW, $clog2(IM_DEPTH), IM address width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_vld  in  1  entry valid.
- wr_rdy  out  1  entry accepted when wr_vld & wr_rdy.
- wr_data  in  DATA_W  entry payload.
- wr_last  in  1  last entry of frame; closes the bank.
- im_wr_en  out  1  IM write strobe.
- im_wr_addr  out  AW  IM write address.
- im_wr_data  out  DATA_W  IM write data.
- im_available  out  im_available_t  {bank_hi, bank_lo} level flags.
- im_consumed  in  im_consumed_t  {bank_hi, bank_lo} single-cycle release pulses.
- im_lo_cnt  out  AW  entries held in bank lo; valid while bank_lo is available.
- im_hi_cnt  out  AW  entries held in bank hi; valid while bank_hi is available.
- im_err  out  1  one-cycle pulse on an illegal consumed pulse.
- stat_frames  out  32  banks published (optional feature).
- stat_stall  out  32  cycles with wr_vld & !wr_rdy (optional feature).

Behaviour:
- Reset: all outputs 0; both banks FREE; write pointer = lo; fill count = 0.
- Per-bank FSM states:
  - FREE -> FILLING on the first accepted entry while the pointer selects that bank.
  - FILLING -> AVAIL on accepting wr_last, or on accepting the entry that makes count == BANK.
  - AVAIL -> FREE on im_consumed.bank_x.
- Bank lo addresses: 0..BANK-1. Bank hi addresses: BANK..2*BANK-1.
- Address = bank base + fill count. Count resets to 0 on bank close.
- wr_rdy = (selected bank is FREE or FILLING); combinational from registered state only, never from wr_vld.
- Latency:
  - im_wr_en/addr/data registered; asserted 1 cycle after the handshake.
  - im_available bit sets 2 cycles after the closing handshake, i.e. 1 cycle after that entry's im_wr_en.
  - im_x_cnt is updated in the same cycle as the bit sets.
- Closing a bank toggles the pointer. If the other bank is AVAIL, wr_rdy drops next cycle until it is released.
- Release: an im_consumed bit on an AVAIL bank clears im_available in the next cycle. wr_rdy may rise in that same next cycle if it was waiting on this bank.
- Consumed pulse on a FREE or FILLING bank: ignored, im_err pulses 1 cycle later, state unchanged.
- Both consumed bits in one cycle: each is handled independently.
- Handshake and release in the same cycle on different banks: both take effect.
- Full-bank close with wr_last also set: a single close, no extra empty bank.
- Entry count uses AW bits; count == BANK is detected as a carry into bit AW-1. No wrap inside a bank.
- Reset mid-frame: all state is lost and IM contents are abandoned; the consumer must be reset together with this block.

Optional Feature:
- Macro: CR_IM_PRODUCER_STATS_EN.
- Defined:
  - stat_frames: 32-bit saturating counter, +1 per bank close.
  - stat_stall: 32-bit saturating counter, +1 per cycle with wr_vld & !wr_rdy.
  - Both reset to 0 and hold at 32'hFFFF_FFFF.
- Undefined: both ports tied 0; no counter flops.

Decomposition:
- cr_im_producer_pkg holds:
  - enum im_bank_state_e {IM_FREE, IM_FILLING, IM_AVAIL};
  - localparam IM_BANK_LO = 0, IM_BANK_HI = 1;
  - stat counter max constant.
- im_available_t and im_consumed_t come from cr_structs.
- Sub-module cr_im_bank_fsm, instantiated twice:
  - inputs: sel, accept, close, consumed.
  - outputs: state, avail, err.
  - The top holds the pointer, fill count, write pipeline and stats.

Test Plan:
- IM_DEPTH=8: write 3 entries, last on 3rd -> im_wr_addr 0,1,2; bank_lo=1 two cycles after 3rd handshake; im_lo_cnt=3; next entry goes to address 4.
- Write 4 entries, no last -> bank_lo closes on full, im_lo_cnt=4 (count==BANK); 5th entry goes to address 4 (bank hi).
- Fill lo and hi without consuming -> wr_rdy=0 and stat_stall increments per wr_vld cycle. Pulse consumed.bank_lo -> bank_lo=0 and wr_rdy=1 next cycle; next address 0.
- consumed.bank_hi while hi FILLING -> im_err pulse, hi stays FILLING, im_available unchanged.
- Consumed lo pulse in the same cycle as hi's closing handshake -> lo FREE and hi AVAIL both take effect; stat_frames increments once.
- Assert rst_n low mid-frame at address 2 -> all outputs 0 asynchronously; first post-reset entry goes to address 0.
